// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the registered immediate generator: RV opcodes, format codes
// and the skid-buffer state encoding.
package imm_gen_pipe_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Pure combinational decoder: raw instruction -> extended immediate, format code and
// illegal flag.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    logic [31:0] imm32;
    logic        sext;
    logic [2:0]  funct3;

    assign funct3 = instr_i[14:12];

    always_comb begin
        imm32     = '0;
        sext      = 1'b0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (instr_i[6:0])
                OP_IMM: begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        fmt_o = FMT_SH;
                        if (XLEN == 64) imm32 = {26'b0, instr_i[25:20]};
                        else            imm32 = {27'b0, instr_i[24:20]};
                    end else begin
                        fmt_o = FMT_I;
                        sext  = 1'b1;
                        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                    end
                end
                LOAD, JALR, SYSTEM: begin
                    fmt_o = FMT_I;
                    sext  = 1'b1;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
                STORE: begin
                    fmt_o = FMT_S;
                    sext  = 1'b1;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                end
                BRANCH: begin
                    fmt_o = FMT_B;
                    sext  = 1'b1;
                    imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                             instr_i[11:8], 1'b0};
                end
                LUI, AUIPC: begin
                    fmt_o = FMT_U;
                    sext  = 1'b1;
                    imm32 = {instr_i[31:12], 12'b0};
                end
                JAL: begin
                    fmt_o = FMT_J;
                    sext  = 1'b1;
                    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                             instr_i[30:21], 1'b0};
                end
                OP: begin
                    fmt_o = FMT_NONE;
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
        // Upper bits above 32 only matter at XLEN=64; the low word overwrites the rest.
        imm_o       = {XLEN{sext & instr_i[31]}};
        imm_o[31:0] = imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes on accept into a 2-entry skid buffer so
// in_ready never depends combinationally on out_ready.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned TAG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [2:0]           out_fmt,
    output logic                 out_illegal,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [31:0]          out_instr
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    imm_decode #(
        .XLEN(XLEN)
    ) u_imm_decode (
        .instr_i  (in_instr),
        .imm_o    (dec_imm),
        .fmt_o    (dec_fmt),
        .illegal_o(dec_illegal)
    );

    buf_state_e state_q, state_d;

    logic [XLEN-1:0]      main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [2:0]           main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;
    logic                 main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
    logic [TAG_WIDTH-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic [31:0]          main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;

    logic accept, pop;
    logic load_main_in, load_main_skid, load_skid;

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d      = StOne;
                    load_main_in = 1'b1;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = StTwo;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    state_d        = StOne;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush wins over any same-cycle accept or pop; dropped data is never loaded.
        if (flush) begin
            state_d        = StEmpty;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_comb begin
        main_imm_d   = main_imm_q;
        main_fmt_d   = main_fmt_q;
        main_ill_d   = main_ill_q;
        main_tag_d   = main_tag_q;
        main_instr_d = main_instr_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;
        skid_tag_d   = skid_tag_q;
        skid_instr_d = skid_instr_q;
        if (load_main_in) begin
            main_imm_d   = dec_imm;
            main_fmt_d   = dec_fmt;
            main_ill_d   = dec_illegal;
            main_tag_d   = in_tag;
            main_instr_d = in_instr;
        end else if (load_main_skid) begin
            main_imm_d   = skid_imm_q;
            main_fmt_d   = skid_fmt_q;
            main_ill_d   = skid_ill_q;
            main_tag_d   = skid_tag_q;
            main_instr_d = skid_instr_q;
        end
        if (load_skid) begin
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_ill_d   = dec_illegal;
            skid_tag_d   = in_tag;
            skid_instr_d = in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            main_imm_q   <= '0;
            main_fmt_q   <= FMT_NONE;
            main_ill_q   <= 1'b0;
            main_tag_q   <= '0;
            main_instr_q <= '0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            skid_ill_q   <= 1'b0;
            skid_tag_q   <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            main_imm_q   <= main_imm_d;
            main_fmt_q   <= main_fmt_d;
            main_ill_q   <= main_ill_d;
            main_tag_q   <= main_tag_d;
            main_instr_q <= main_instr_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
            skid_tag_q   <= skid_tag_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign out_imm     = main_imm_q;
    assign out_fmt     = main_fmt_q;
    assign out_illegal = main_ill_q;
    assign out_tag     = main_tag_q;
    assign out_instr   = main_instr_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance share one input
// stream; outputs are sampled 1 time unit after each rising edge.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_tag, out_instr;
    logic [2:0]  out_fmt;

    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_out_imm;
    logic [31:0] w_out_tag, w_out_instr;
    logic [2:0]  w_out_fmt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_tag(out_tag), .out_instr(out_instr)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_WIDTH(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_imm(w_out_imm),
        .out_fmt(w_out_fmt), .out_illegal(w_out_illegal), .out_tag(w_out_tag),
        .out_instr(w_out_instr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one edge, then check the registered result.
    task automatic push_check(input string tag, input logic [31:0] instr,
                              input logic [31:0] imm, input logic [2:0] fmt,
                              input logic ill);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = instr ^ 32'hA5A5_0000;
        step();
        in_valid = 1'b0;
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".imm"},   64'(out_imm),   64'(imm));
        check({tag, ".fmt"},   64'(out_fmt),   64'(fmt));
        check({tag, ".ill"},   64'(out_illegal), 64'(ill));
        check({tag, ".tag"},   64'(out_tag),   64'(instr ^ 32'hA5A5_0000));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #12;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.ready", 64'(in_ready), 64'd1);
        check("rst.imm",   64'(out_imm), 64'd0);
        check("rst.fmt",   64'(out_fmt), 64'd0);
        check("rst.tag",   64'(out_tag), 64'd0);
        check("rst.instr", 64'(out_instr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single store, 1-cycle latency
        push_check("sw", 32'hFE51_2E23, 32'hFFFF_FFFC, 3'd2, 1'b0);

        // Back-to-back stream, no bubbles
        in_valid = 1'b1;
        in_instr = 32'h1234_50B7; in_tag = 32'h10;
        step();
        check("lui.imm", 64'(out_imm), 64'h1234_5000);
        check("lui.fmt", 64'(out_fmt), 64'd4);
        check("lui.tag", 64'(out_tag), 64'h10);
        in_instr = 32'hFF9F_F06F; in_tag = 32'h14;
        step();
        check("jal.valid", 64'(out_valid), 64'd1);
        check("jal.imm", 64'(out_imm), 64'hFFFF_FFF8);
        check("jal.fmt", 64'(out_fmt), 64'd5);
        check("jal.tag", 64'(out_tag), 64'h14);
        in_instr = 32'h0000_0863; in_tag = 32'h18;
        step();
        check("beq.valid", 64'(out_valid), 64'd1);
        check("beq.imm", 64'(out_imm), 64'h10);
        check("beq.fmt", 64'(out_fmt), 64'd3);
        in_valid = 1'b0;
        step();
        check("drain.valid", 64'(out_valid), 64'd0);

        // Shift amount and XLEN=64 extension
        push_check("srai", 32'h4030_D093, 32'h3, 3'd6, 1'b0);
        check("srai64.imm", w_out_imm, 64'h3);
        push_check("srai35", 32'h4230_D093, 32'h3, 3'd6, 1'b0);
        check("srai35_64.imm", w_out_imm, 64'd35);
        push_check("addi", 32'hFFF0_0013, 32'hFFFF_FFFF, 3'd1, 1'b0);
        check("addi64.imm", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        push_check("lui64", 32'h8000_0037, 32'h8000_0000, 3'd4, 1'b0);
        check("lui64.imm", w_out_imm, 64'hFFFF_FFFF_8000_0000);

        // Illegal and NONE encodings
        push_check("op7f", 32'h0000_007F, 32'h0, 3'd0, 1'b1);
        push_check("c01", 32'h0000_0001, 32'h0, 3'd0, 1'b1);
        push_check("neg_ill", 32'hFFFF_FFFF, 32'h0, 3'd0, 1'b1);
        push_check("add", 32'h8000_0033, 32'h0, 3'd0, 1'b0);
        step();

        // Backpressure: two accepted, third stalled, outputs stable, then in-order drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0010_0093; in_tag = 32'h1;
        step();
        check("bp1.ready", 64'(in_ready), 64'd1);
        check("bp1.imm", 64'(out_imm), 64'd1);
        in_instr = 32'h0020_0093; in_tag = 32'h2;
        step();
        check("bp2.ready", 64'(in_ready), 64'd0);
        check("bp2.imm", 64'(out_imm), 64'd1);
        in_instr = 32'h0030_0093; in_tag = 32'h3;
        step();
        step();
        check("bp3.ready", 64'(in_ready), 64'd0);
        check("bp3.imm", 64'(out_imm), 64'd1);
        check("bp3.tag", 64'(out_tag), 64'd1);
        check("bp3.instr", 64'(out_instr), 64'h0010_0093);
        out_ready = 1'b1;
        step();
        check("dr1.imm", 64'(out_imm), 64'd2);
        check("dr1.ready", 64'(in_ready), 64'd1);
        step();
        check("dr2.imm", 64'(out_imm), 64'd3);
        check("dr2.tag", 64'(out_tag), 64'd3);
        in_valid = 1'b0;
        step();
        check("dr3.valid", 64'(out_valid), 64'd0);

        // Flush from TWO with a simultaneous input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0040_0093;
        step();
        in_instr = 32'h0050_0093;
        step();
        check("pre_flush.ready", 64'(in_ready), 64'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'h0060_0093;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.valid", 64'(out_valid), 64'd0);
        check("flush.ready", 64'(in_ready), 64'd1);
        step();
        step();
        check("flush_after.valid", 64'(out_valid), 64'd0);

        // Flush from ONE with accept: input dropped
        in_valid = 1'b1;
        in_instr = 32'h0070_0093;
        out_ready = 1'b0;
        step();
        flush = 1'b1;
        in_instr = 32'h0080_0093;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush1.valid", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        in_instr = 32'hFE51_2E23; in_tag = 32'hBEEF;
        step();
        check("prerst.valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 64'(out_valid), 64'd0);
        check("arst.imm",   64'(out_imm), 64'd0);
        check("arst.tag",   64'(out_tag), 64'd0);
        check("arst.instr", 64'(out_instr), 64'd0);
        check("arst.ready", 64'(in_ready), 64'd1);
        check("arst64.imm", w_out_imm, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst.valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
